// File: rtl/mram_pkg.sv
// Shared types and helpers for the multi-client byte-lane RAM.
// Holds the clear/run state encoding, width limits and the helper that
// slices one client's field out of a packed per-client port vector.
package mram_pkg;

  typedef enum logic [0:0] {
    MRAM_CLEAR = 1'b0,
    MRAM_RUN   = 1'b1
  } mram_state_e;

  localparam int MAX_BYTES   = 8;
  localparam int MAX_CLIENTS = 8;
  // Widest packed per-client vector the helper below accepts.
  localparam int MAX_VEC     = MAX_CLIENTS * MAX_BYTES * 8;

  // Return field idx (width bits, width <= 64) of a packed client vector.
  function automatic logic [63:0] field_get(input logic [MAX_VEC-1:0] vec,
                                            input int idx,
                                            input int width);
    logic [MAX_VEC-1:0] shifted;
    logic [63:0]        mask;
    shifted = vec >> (idx * width);
    mask    = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    return shifted[63:0] & mask;
  endfunction

endpackage

// File: rtl/ssbus_if.sv
// Save-state bus. The master raises read or write (or query for the setup
// handshake) with select/addr/data and holds it until it sees ack for one
// cycle; the slave answers a read with the word zero-extended in data_out and
// a query with {size[31:0], width_flag[31:0]} in data_out.
interface ssbus_if;

  logic [7:0]  select;
  logic [31:0] addr;
  logic [63:0] data;
  logic        read;
  logic        write;
  logic        query;
  logic [63:0] data_out;
  logic        ack;

  modport slave  (input select, addr, data, read, write, query, output data_out, ack);
  modport master (output select, addr, data, read, write, query, input data_out, ack);

endinterface

// File: rtl/multiport_byte_ram_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// pointer in the same cycle, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] eligible_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan ptr, ptr+1, ... for the first eligible client and compute the new pointer.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    valid_o = 1'b0;
    ptr_d   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!valid_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
        ptr_d        = (idx == N - 1) ? '0 : PW'(idx + 1);
      end else begin
        grant_o = grant_o;
      end
    end
  end

  // Pointer register, cleared by synchronous reset and held when nothing wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multiport_byte_ram.sv
// Shared byte-enabled RAM for NUM_CLIENTS request/ack clients plus a
// save-state port that pre-empts every client. One access per clock,
// registered read data and one-cycle ack pulses.
// Build option MRAM_INIT_CLEAR_EN: zero the whole array after reset
// release before accepting client requests.
module multiport_byte_ram
  import mram_pkg::*;
#(
  parameter int WIDTHAD     = 10,
  parameter int BYTES       = 2,
  parameter int NUM_CLIENTS = 3,
  parameter int SS_IDX      = -1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             ready,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS-1:0]           we,
  input  logic [NUM_CLIENTS*BYTES-1:0]     be,
  input  logic [NUM_CLIENTS*WIDTHAD-1:0]   addr,
  input  logic [NUM_CLIENTS*8*BYTES-1:0]   wdata,
  output logic [NUM_CLIENTS-1:0]           ack,
  output logic [8*BYTES-1:0]               rdata,
  ssbus_if.slave                           ssbus
);

  localparam int DW    = 8 * BYTES;
  localparam int DEPTH = 2 ** WIDTHAD;
  localparam int CIW   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

`ifdef MRAM_INIT_CLEAR_EN
  localparam mram_state_e RESET_STATE = MRAM_CLEAR;
`else
  localparam mram_state_e RESET_STATE = MRAM_RUN;
`endif

  logic [DW-1:0]          mem_q [DEPTH];

  mram_state_e            state_q;
  mram_state_e            state_d;
  logic                   ready_q;
  logic                   ready_d;
  logic [NUM_CLIENTS-1:0] ack_q;
  logic [DW-1:0]          rdata_q;
  logic                   ss_ack_q;
  logic [63:0]            ss_dout_q;

  logic                   ss_sel_s;
  logic                   ss_access_s;
  logic                   ss_op_s;
  logic                   ss_setup_s;
  logic [NUM_CLIENTS-1:0] elig_s;
  logic [NUM_CLIENTS-1:0] grant_s;
  logic                   grant_valid_s;
  logic [CIW-1:0]         gidx_s;
  logic                   cl_we_s;
  logic [BYTES-1:0]       cl_be_s;
  logic [WIDTHAD-1:0]     cl_addr_s;
  logic [DW-1:0]          cl_wdata_s;
  logic [DW-1:0]          cl_post_s;
  logic [WIDTHAD-1:0]     rd_addr_s;
  logic [DW-1:0]          mem_rd_s;
  logic                   mem_we_s;
  logic [BYTES-1:0]       mem_wbe_s;
  logic [WIDTHAD-1:0]     mem_waddr_s;
  logic [DW-1:0]          mem_wdata_s;
  logic                   clear_we_s;
  logic [WIDTHAD-1:0]     clr_addr_s;

`ifdef MRAM_INIT_CLEAR_EN
  logic [WIDTHAD-1:0]     clr_cnt_q;
  logic [WIDTHAD-1:0]     clr_cnt_d;
`endif

  // A negative SS_IDX answers on every select value.
  assign ss_sel_s    = (SS_IDX < 0) || (ssbus.select == 8'(SS_IDX));
  assign ss_access_s = ss_sel_s & (ssbus.read | ssbus.write);
  // The held request is served once; the ack cycle is the idle half of the handshake.
  assign ss_op_s     = ss_access_s & ~ss_ack_q & reset_n;
  assign ss_setup_s  = ss_sel_s & ssbus.query & ~ss_access_s & ~ss_ack_q & reset_n;

  // A client just acked is masked so continuous requesters rotate fairly.
  assign elig_s = req & ~ack_q & {NUM_CLIENTS{ready_q & reset_n & ~ss_access_s}};

  rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .eligible_i (elig_s),
    .grant_o    (grant_s),
    .valid_o    (grant_valid_s)
  );

`ifdef MRAM_INIT_CLEAR_EN
  assign clear_we_s = (state_q == MRAM_CLEAR) & ~ss_access_s & reset_n;
`else
  assign clear_we_s = 1'b0;
`endif

  // One-hot grant to index, then pick that client's request fields.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      gidx_s = grant_s[i] ? CIW'(i) : gidx_s;
    end
    cl_we_s    = we[gidx_s];
    cl_be_s    = BYTES'(field_get(MAX_VEC'(be), int'(gidx_s), BYTES));
    cl_addr_s  = WIDTHAD'(field_get(MAX_VEC'(addr), int'(gidx_s), WIDTHAD));
    cl_wdata_s = DW'(field_get(MAX_VEC'(wdata), int'(gidx_s), DW));
  end

  // Current word at the access address and the client's byte-merged result.
  always_comb begin
    rd_addr_s = ss_op_s ? ssbus.addr[WIDTHAD-1:0] : cl_addr_s;
    mem_rd_s  = mem_q[rd_addr_s];
    cl_post_s = mem_rd_s;
    for (int b = 0; b < BYTES; b++) begin
      cl_post_s[b*8 +: 8] = cl_be_s[b] ? cl_wdata_s[b*8 +: 8] : mem_rd_s[b*8 +: 8];
    end
  end

  // Single write port: save-state first, then the granted client, then the clear sweep.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_wbe_s   = '0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (ss_op_s && ssbus.write) begin
      mem_we_s    = 1'b1;
      mem_wbe_s   = '1;
      mem_waddr_s = ssbus.addr[WIDTHAD-1:0];
      mem_wdata_s = ssbus.data[DW-1:0];
    end else if (grant_valid_s && cl_we_s) begin
      mem_we_s    = 1'b1;
      mem_wbe_s   = cl_be_s;
      mem_waddr_s = cl_addr_s;
      mem_wdata_s = cl_wdata_s;
    end else if (clear_we_s) begin
      mem_we_s    = 1'b1;
      mem_wbe_s   = '1;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = '0;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; byte lanes written independently, contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_wbe_s[b]) begin
          mem_q[mem_waddr_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
        end
      end
    end
  end

  // FSM state register with the clear address counter and registered ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      ready_q   <= 1'b0;
`ifdef MRAM_INIT_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
`ifdef MRAM_INIT_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // FSM next state: sweep every address once, pausing while save-state owns the port.
  always_comb begin
`ifdef MRAM_INIT_CLEAR_EN
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      MRAM_CLEAR: begin
        if (clear_we_s) begin
          clr_cnt_d = clr_cnt_q + WIDTHAD'(1);
          if (clr_cnt_q == {WIDTHAD{1'b1}}) begin
            state_d = MRAM_RUN;
          end else begin
            state_d = MRAM_CLEAR;
          end
        end else begin
          state_d = MRAM_CLEAR;
        end
      end
      MRAM_RUN: state_d = MRAM_RUN;
      default:  state_d = MRAM_CLEAR;
    endcase
`else
    state_d = MRAM_RUN;
`endif
  end

  // FSM outputs: ready follows the upcoming state, clear address from the counter.
  always_comb begin
    ready_d = (state_d == MRAM_RUN);
`ifdef MRAM_INIT_CLEAR_EN
    clr_addr_s = clr_cnt_q;
`else
    clr_addr_s = '0;
`endif
  end

  // Client ack pulses, shared read data and save-state responses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_q     <= '0;
      rdata_q   <= '0;
      ss_ack_q  <= 1'b0;
      ss_dout_q <= '0;
    end else begin
      ack_q    <= grant_s;
      ss_ack_q <= ss_op_s | ss_setup_s;
      if (grant_valid_s) begin
        rdata_q <= cl_we_s ? cl_post_s : mem_rd_s;
      end else begin
        rdata_q <= rdata_q;
      end
      if (ss_op_s && ssbus.read) begin
        ss_dout_q <= 64'(mem_rd_s);
      end else if (ss_setup_s) begin
        ss_dout_q <= {32'(DEPTH), 32'd1};
      end else begin
        ss_dout_q <= ss_dout_q;
      end
    end
  end

  assign ready          = ready_q;
  assign ack            = ack_q;
  assign rdata          = rdata_q;
  assign ssbus.ack      = ss_ack_q;
  assign ssbus.data_out = ss_dout_q;

endmodule

// File: doc/multiport_byte_ram.md
Name: multiport_byte_ram

Overview:
Shared byte-enabled RAM serving NUM_CLIENTS request/ack clients through a round-robin arbiter, at most one access per clock. Read data is registered. It has a save-state (ssbus) slave port that takes priority over all clients. It is the successor to the single-client 68k byte-lane RAM, for shared work RAM, e.g. a CPU plus DMA plus a video reader.

Parameters:
WIDTHAD, 10, word address width; depth = 2**WIDTHAD
BYTES, 2, bytes per word; data width DW = 8*BYTES, max 8
NUM_CLIENTS, 3, number of client ports, 1..8
SS_IDX, -1, save-state bus index passed to ssbus.setup/access

Ports:
clock  in  1  sole clock, all logic posedge
reset_n  in  1  synchronous, active-low reset
ready  out  1  RAM accepting requests
req  in  NUM_CLIENTS  per-client request, held until ack
we  in  NUM_CLIENTS  per-client write (1) / read (0)
be  in  NUM_CLIENTS*BYTES  per-client byte enables, client i at [i*BYTES +: BYTES]
addr  in  NUM_CLIENTS*WIDTHAD  per-client word address
wdata  in  NUM_CLIENTS*DW  per-client write data
ack  out  NUM_CLIENTS  one-cycle completion pulse per client
rdata  out  DW  shared read data, valid when any ack bit is 1
ssbus  slave  ssbus_if  save-state access, size 2**WIDTHAD, setup width flag 1

Behaviour:
- Reset (reset_n=0 at a clock edge): ack=0, rdata=0, round-robin pointer=0, ready=0. RAM contents are unchanged unless MRAM_INIT_CLEAR_EN is defined.
- Eligible client i: req[i]=1, ack[i]=0 in the current cycle, and ready=1. A client that sees ack must idle at least one cycle before its next request is eligible.
- Grant: first eligible client scanning ptr, ptr+1, … mod NUM_CLIENTS. After a grant, ptr = granted+1 mod N. If nothing is granted, ptr is held.
- Granted access happens on the same edge.
  - Write: bytes with be=1 are updated and others kept. be=0 on a write still acks and writes nothing.
  - Read: full word loaded into rdata.
- Latency: grant in cycle t gives ack[i]=1 in t+1, with rdata valid in t+1 for reads. rdata after a write ack = post-write word. rdata holds its value between reads.
- Throughput: one access per cycle total. With all N clients holding req, each is served once per N cycles (a client's masked ack cycle never starves the others).
- ssbus priority: when ssbus.access(SS_IDX) is true, no client is granted.
  - Write: all bytes written from ssbus.data[DW-1:0], then write_ack.
  - Read: read_response with the word zero-extended to 64 bits.
  - Pending requests simply wait.
- Address wraps naturally modulo depth; no bounds errors.
- Simultaneous write by client and ssbus is impossible (ssbus excludes grant).
- Reset mid-transaction: any ack due next cycle is suppressed. Clients must re-request.

Optional Feature:
MRAM_INIT_CLEAR_EN
- Defined: after reset release, FSM CLEAR writes zero to address 0..2**WIDTHAD-1, one per cycle.
  - ready=0 and no grants during CLEAR; ssbus access during CLEAR stalls the clear counter.
  - Enters RUN (ready=1) the cycle after the last address.
  - Reset during CLEAR restarts at 0.
- Undefined: FSM is RUN only; ready=1 from the first cycle after reset_n=1. No clear occurs.

Decomposition:
- Package mram_pkg: state enum (MRAM_CLEAR, MRAM_RUN), localparam MAX_BYTES=8, and a helper function to extract client fields from the packed vectors.
- Sub-module rr_arbiter (parameter N): inputs eligible vector and clock/reset_n; outputs one-hot grant and valid; owns the pointer.

Test Plan:
- Reset then client0 writes addr 0x010, data 0xBEEF, be=11; reads back -> ack at t+1 each, rdata=0xBEEF.
- Partial write: 0x1234 stored, client1 writes 0xAB00 be=10 -> read returns 0xAB34.
- All 3 clients hold req continuously for 12 cycles -> grants 0,1,2,0,1,2 …; each acked 4 times; no client gets two acks within 3 cycles.
- ssbus write addr 5 data 0x55AA while client2 requests -> write_ack first, client2 acked the cycle after ssbus releases; ssbus read returns 64'h55AA.
- Address 0x3FF write then 0x000 read with WIDTHAD=10 -> no aliasing; reset asserted on grant cycle -> no ack next cycle.
- MRAM_INIT_CLEAR_EN: preload memory, reset -> ready low exactly 1024 cycles, all reads return 0; without the macro ready=1 the cycle after reset release.
